passcode_sequencer: RTL and testbench

- Keypad-side front end of the door-code check.
- Collects DIGITS keypad digits, then feeds each entered digit and its stored digit, one pair at a time, into the registered 4-bit comparator. The comparator samples on cmp_en, and its equality result is valid one cycle later.
- Declares unlock or fail.
- Counts consecutive failures and enforces a timed lockout after MAX_TRIES failures.

---
 rtl/security_pkg.sv | 16 +
 rtl/lockout_timer.sv | 35 +++
 rtl/passcode_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_passcode_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/security_pkg.sv
// Shared definitions for the door-code security blocks: digit width and
// the passcode sequencer's state encoding.
package security_pkg;

  localparam int DIGIT_W   = 4;
  localparam int MAX_DIGIT = 9;

  typedef enum logic [2:0] {
    ST_ENTRY,
    ST_ISSUE,
    ST_SAMPLE,
    ST_RESULT,
    ST_LOCKOUT
  } state_t;

endpackage

// File: rtl/lockout_timer.sv
// Loadable down-counter. Signals done in the last counting cycle, so a
// load of CYCLES gives exactly CYCLES enabled cycles before expiry.
module lockout_timer #(
  parameter int CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  localparam int W = $clog2(CYCLES + 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = W'(CYCLES);
    end else if (en_i && count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, matching the hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign done_o = en_i && (count_q == W'(1));

endmodule

// File: rtl/passcode_sequencer.sv
// Keypad front end of the door-code check: collects digits, streams the
// entered/stored pairs through an external registered comparator, and
// declares unlock/fail with a timed lockout after repeated failures.
module passcode_sequencer
  import security_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 1000,
  localparam int CNT_W      = $clog2(DIGITS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      key_valid,
  input  logic [DIGIT_W-1:0]        key_digit,
  input  logic                      key_clear,
  input  logic [DIGIT_W*DIGITS-1:0] stored_code,
  output logic [DIGIT_W-1:0]        cmp_a,
  output logic [DIGIT_W-1:0]        cmp_b,
  output logic                      cmp_en,
  input  logic                      cmp_eq,
  output logic [CNT_W-1:0]          digit_count,
  output logic                      busy,
  output logic                      unlock,
  output logic                      fail,
  output logic                      locked
);

  localparam int FAIL_W = $clog2(MAX_TRIES + 1);

  function automatic logic [DIGIT_W-1:0] digit_of(
    input logic [DIGIT_W*DIGITS-1:0] vec,
    input int                        idx
  );
    return vec[DIGIT_W*idx +: DIGIT_W];
  endfunction

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [FAIL_W-1:0]         fails_q, fails_d;
  logic [DIGIT_W*DIGITS-1:0] entry_q, entry_d;
  logic                      match_q, match_d;
  logic [DIGIT_W-1:0]        cmp_a_q, cmp_a_d;
  logic [DIGIT_W-1:0]        cmp_b_q, cmp_b_d;
  logic                      cmp_en_q, cmp_en_d;
  logic                      busy_q, busy_d;
  logic                      unlock_q, unlock_d;
  logic                      fail_q, fail_d;
  logic                      locked_q, locked_d;
  logic                      timer_load, timer_en, timer_done;

  lockout_timer #(
    .CYCLES (LOCK_CYCLES)
  ) u_lockout_timer (
    .clk    (clk),
    .rst_n  (rst),
    .load_i (timer_load),
    .en_i   (timer_en),
    .done_o (timer_done)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    count_d    = count_q;
    fails_d    = fails_q;
    entry_d    = entry_q;
    match_d    = match_q;
    cmp_a_d    = cmp_a_q;
    cmp_b_d    = cmp_b_q;
    cmp_en_d   = 1'b0;
    busy_d     = busy_q;
    unlock_d   = 1'b0;
    fail_d     = 1'b0;
    locked_d   = locked_q;
    timer_load = 1'b0;
    timer_en   = 1'b0;

    unique case (state_q)
      ST_ENTRY: begin
        if (key_clear) begin
          count_d = '0;
        end else if (key_valid && key_digit <= DIGIT_W'(MAX_DIGIT)) begin
          entry_d[DIGIT_W*int'(count_q) +: DIGIT_W] = key_digit;
          count_d = count_q + CNT_W'(1);
          if (count_q == CNT_W'(DIGITS - 1)) begin
            // First pair is issued straight away; digit 0 may be the key just accepted.
            state_d  = ST_ISSUE;
            idx_d    = '0;
            match_d  = 1'b1;
            busy_d   = 1'b1;
            cmp_en_d = 1'b1;
            cmp_a_d  = digit_of(entry_d, 0);
            cmp_b_d  = digit_of(stored_code, 0);
          end
        end
      end

      ST_ISSUE: state_d = ST_SAMPLE;

      ST_SAMPLE: begin
        match_d = match_q & cmp_eq;
        if (idx_q == CNT_W'(DIGITS - 1)) begin
          state_d  = ST_RESULT;
          unlock_d = match_d;
          fail_d   = !match_d;
          if (match_d) begin
            fails_d = '0;
          end else if (fails_q != FAIL_W'(MAX_TRIES)) begin
            fails_d = fails_q + FAIL_W'(1);
          end
        end else begin
          idx_d    = idx_q + CNT_W'(1);
          state_d  = ST_ISSUE;
          cmp_en_d = 1'b1;
          cmp_a_d  = digit_of(entry_q, int'(idx_d));
          cmp_b_d  = digit_of(stored_code, int'(idx_d));
        end
      end

      ST_RESULT: begin
        count_d = '0;
        if (fail_q && fails_q == FAIL_W'(MAX_TRIES)) begin
          state_d    = ST_LOCKOUT;
          locked_d   = 1'b1;
          timer_load = 1'b1;
        end else begin
          state_d = ST_ENTRY;
          busy_d  = 1'b0;
        end
      end

      ST_LOCKOUT: begin
        timer_en = 1'b1;
        if (timer_done) begin
          state_d  = ST_ENTRY;
          locked_d = 1'b0;
          busy_d   = 1'b0;
          fails_d  = '0;
        end
      end

      default: state_d = ST_ENTRY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_ENTRY;
      idx_q    <= '0;
      count_q  <= '0;
      fails_q  <= '0;
      // NOTE: the entry buffer is reset along with the control state so no
      // digits from an aborted attempt survive a reset.
      entry_q  <= '0;
      match_q  <= 1'b0;
      cmp_a_q  <= '0;
      cmp_b_q  <= '0;
      cmp_en_q <= 1'b0;
      busy_q   <= 1'b0;
      unlock_q <= 1'b0;
      fail_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      count_q  <= count_d;
      fails_q  <= fails_d;
      entry_q  <= entry_d;
      match_q  <= match_d;
      cmp_a_q  <= cmp_a_d;
      cmp_b_q  <= cmp_b_d;
      cmp_en_q <= cmp_en_d;
      busy_q   <= busy_d;
      unlock_q <= unlock_d;
      fail_q   <= fail_d;
      locked_q <= locked_d;
    end
  end

  assign cmp_a       = cmp_a_q;
  assign cmp_b       = cmp_b_q;
  assign cmp_en      = cmp_en_q;
  assign digit_count = count_q;
  assign busy        = busy_q;
  assign unlock      = unlock_q;
  assign fail        = fail_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_passcode_sequencer.sv
// Bench for passcode_sequencer with an attached registered comparator; a
// timeline model of each check is compared against the outputs every cycle.
module tb_passcode_sequencer;

  localparam int DIGITS    = 4;
  localparam int MAX_TRIES = 3;
  localparam int LOCK      = 20;
  localparam int END_CHECK = 2 * DIGITS + 1;

  logic        clk;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic        key_clear;
  logic [15:0] stored_code;
  logic [3:0]  cmp_a, cmp_b;
  logic        cmp_en, cmp_eq;
  logic [2:0]  digit_count;
  logic        busy, unlock, fail, locked;

  int total = 0;
  int bad   = 0;

  passcode_sequencer #(
    .DIGITS      (DIGITS),
    .MAX_TRIES   (MAX_TRIES),
    .LOCK_CYCLES (LOCK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .key_clear   (key_clear),
    .stored_code (stored_code),
    .cmp_a       (cmp_a),
    .cmp_b       (cmp_b),
    .cmp_en      (cmp_en),
    .cmp_eq      (cmp_eq),
    .digit_count (digit_count),
    .busy        (busy),
    .unlock      (unlock),
    .fail        (fail),
    .locked      (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External registered comparator sharing clk/rst with the block.
  always @(posedge clk or negedge rst) begin
    if (!rst)        cmp_eq <= 1'b0;
    else if (cmp_en) cmp_eq <= (cmp_a == cmp_b);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: t counts cycles since the final digit was accepted (0 = entering keys).
  typedef struct packed {
    int          t;
    int          cnt;
    int          fails;
    logic        lock;
    logic        match;
    logic [15:0] entry;
    logic [3:0]  a;
    logic [3:0]  b;
  } model_t;

  model_t m;

  function automatic model_t step(input model_t cur, input logic kv, input logic [3:0] kd,
                                  input logic kc, input logic [15:0] code);
    model_t n = cur;
    if (cur.t > 0) begin
      n.t = cur.t + 1;
      if (n.t == END_CHECK + 1) n.cnt = 0;
      if (n.t > (cur.lock ? END_CHECK + LOCK : END_CHECK)) begin
        n.t = 0;
        if (cur.lock) begin
          n.lock  = 1'b0;
          n.fails = 0;
        end
      end else if (n.t < 2 * DIGITS && n.t % 2 == 1) begin
        n.a = cur.entry[4*((n.t-1)/2) +: 4];
        n.b = code[4*((n.t-1)/2) +: 4];
      end
    end else if (kc) begin
      n.cnt = 0;
    end else if (kv && kd <= 4'd9) begin
      n.entry[4*cur.cnt +: 4] = kd;
      n.cnt = cur.cnt + 1;
      if (n.cnt == DIGITS) begin
        n.t     = 1;
        n.match = (n.entry == code);
        n.a     = n.entry[3:0];
        n.b     = code[3:0];
        n.fails = n.match ? 0 : ((cur.fails < MAX_TRIES) ? cur.fails + 1 : MAX_TRIES);
        n.lock  = (n.fails == MAX_TRIES);
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= '0;
    else      m <= step(m, key_valid, key_digit, key_clear, stored_code);
  end

  always @(negedge clk) begin
    check("busy",        32'(busy),        32'(m.t > 0));
    check("cmp_en",      32'(cmp_en),      32'(m.t % 2 == 1 && m.t < 2 * DIGITS));
    check("cmp_a",       32'(cmp_a),       32'(m.a));
    check("cmp_b",       32'(cmp_b),       32'(m.b));
    check("unlock",      32'(unlock),      32'(m.t == END_CHECK && m.match));
    check("fail",        32'(fail),        32'(m.t == END_CHECK && !m.match));
    check("locked",      32'(locked),      32'(m.lock && m.t > END_CHECK));
    check("digit_count", 32'(digit_count), 32'(m.cnt));
  end

  typedef struct {
    int          unlock_cyc;
    int          fail_cyc;
    int          unlock_n;
    int          fail_n;
    int          en_n;
    int          locked_n;
    logic [31:0] pairs;
  } obs_t;

  task automatic press(input logic v, input logic [3:0] d, input logic c);
    @(negedge clk);
    key_valid = v;
    key_digit = d;
    key_clear = c;
    @(negedge clk);
    key_valid = 1'b0;
    key_clear = 1'b0;
  endtask

  // keys[3:0] is the first key pressed.
  task automatic enter_code(input logic [15:0] keys);
    for (int k = 0; k < DIGITS; k++) press(1'b1, keys[4*k +: 4], 1'b0);
  endtask

  // Called mid-cycle 1 after the final key; records n cycles of activity.
  task automatic observe(input int n, output obs_t o);
    o = '{0, 0, 0, 0, 0, 0, 32'h0};
    for (int k = 1; k <= n; k++) begin
      if (unlock) begin o.unlock_cyc = k; o.unlock_n++; end
      if (fail)   begin o.fail_cyc = k;   o.fail_n++;   end
      if (cmp_en) begin o.pairs = {o.pairs[23:0], cmp_a, cmp_b}; o.en_n++; end
      if (locked) o.locked_n++;
      @(negedge clk);
    end
  endtask

  obs_t o;

  initial begin
    rst         = 1'b1;
    key_valid   = 1'b0;
    key_digit   = 4'd0;
    key_clear   = 1'b0;
    stored_code = 16'h4321;
    #3 rst = 1'b0;
    #1;
    check("rst_cmp_a",  32'(cmp_a),  32'h0);
    check("rst_cmp_en", 32'(cmp_en), 32'h0);
    check("rst_busy",   32'(busy),   32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    check("rst_count",  32'(digit_count), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Correct code 1,2,3,4.
    enter_code(16'h4321);
    observe(10, o);
    check("t1_unlock_cycle", 32'(o.unlock_cyc), 32'd9);
    check("t1_unlock_pulses", 32'(o.unlock_n), 32'd1);
    check("t1_fail_pulses",  32'(o.fail_n),   32'd0);
    check("t1_cmp_en_pulses", 32'(o.en_n),    32'd4);
    check("t1_pairs",        o.pairs,         32'h11223344);
    check("t1_count_after",  32'(digit_count), 32'd0);

    // Wrong last digit 1,2,3,5.
    enter_code(16'h5321);
    observe(10, o);
    check("t2_fail_cycle",   32'(o.fail_cyc), 32'd9);
    check("t2_unlock_pulses", 32'(o.unlock_n), 32'd0);
    check("t2_pairs",        o.pairs,         32'h11223354);

    // Invalid key ignored, clear beats a simultaneous valid key.
    press(1'b1, 4'd1, 1'b0);
    press(1'b1, 4'd12, 1'b0);
    press(1'b1, 4'd2, 1'b0);
    check("t3_count_two",    32'(digit_count), 32'd2);
    press(1'b1, 4'd3, 1'b1);
    check("t3_count_clear",  32'(digit_count), 32'd0);
    enter_code(16'h4321);
    observe(10, o);
    check("t3_unlock_pulses", 32'(o.unlock_n), 32'd1);

    // Two wrong, one right, two wrong: no lockout.
    for (int r = 0; r < 5; r++) begin
      enter_code(r == 2 ? 16'h4321 : 16'h1111);
      observe(12, o);
      check("t4_no_lock", 32'(o.locked_n), 32'd0);
    end
    check("t4_idle_busy", 32'(busy), 32'd0);
    enter_code(16'h4321);
    observe(10, o);
    check("t4_unlock_pulses", 32'(o.unlock_n), 32'd1);

    // Three consecutive wrong codes trigger a LOCK-cycle lockout.
    for (int r = 0; r < 2; r++) begin
      enter_code(16'h9999);
      observe(10, o);
    end
    enter_code(16'h9999);
    fork
      observe(40, o);
      begin
        repeat (14) @(negedge clk);
        enter_code(16'h4321);
        press(1'b1, 4'd5, 1'b1);
      end
    join
    check("t5_fail_pulses",   32'(o.fail_n),   32'd1);
    check("t5_locked_cycles", 32'(o.locked_n), 32'd20);
    check("t5_cmp_en_pulses", 32'(o.en_n),     32'd4);
    check("t5_unlock_pulses", 32'(o.unlock_n), 32'd0);
    check("t5_count_after",   32'(digit_count), 32'd0);
    enter_code(16'h4321);
    observe(10, o);
    check("t5_unlock_after",  32'(o.unlock_n), 32'd1);

    // Reset during the SAMPLE cycle of digit 2 aborts the check.
    enter_code(16'h4321);
    repeat (5) @(negedge clk);
    check("t6_busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_busy",   32'(busy),   32'h0);
    check("t6_rst_cmp_b",  32'(cmp_b),  32'h0);
    check("t6_rst_count",  32'(digit_count), 32'h0);
    check("t6_rst_unlock", 32'(unlock), 32'h0);
    check("t6_rst_fail",   32'(fail),   32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    observe(6, o);
    check("t6_no_unlock", 32'(o.unlock_n), 32'd0);
    check("t6_no_fail",   32'(o.fail_n),   32'd0);
    check("t6_count",     32'(digit_count), 32'd0);
    enter_code(16'h4321);
    observe(10, o);
    check("t6_unlock_after", 32'(o.unlock_n), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
